// File: rtl/qspi_rx_latency_align.sv
// QSPI read-data realignment: delays each sample request by a strapped latency and packs beats into words.
// Latency: word_valid pulses the cycle after the edge that captures the last beat (L clocks after its request).
// Backpressure: none; sample_req accepted every cycle. Runtime latency writes need define QSPI_RX_LAT_WR_EN.
module qspi_rx_latency_align #(
    parameter int DATA_W    = 4,
    parameter int WORD_W    = 8,
    parameter int MAX_LAT   = 7,
    parameter int LAT_W     = 3,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LAT_W-1:0]  strap_lat,
    input  logic              sample_req,
    input  logic              abort,
    input  logic [DATA_W-1:0] qspi_data_in,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    output logic              busy,
    output logic [LAT_W-1:0]  latency
`ifdef QSPI_RX_LAT_WR_EN
    ,
    input  logic              lat_wr_en,
    input  logic [LAT_W-1:0]  lat_wr_data,
    output logic              lat_wr_err
`endif
);

    localparam int BEATS = WORD_W / DATA_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] v);
        return (v > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : v;
    endfunction

    logic [LAT_W-1:0]   lat_q;
    logic [LAT_W-1:0]   lat_eff;
    logic [MAX_LAT-1:0] dl_q, dl_next, lat_mask;
    logic               capture, capture_dl;
    logic [CNT_W-1:0]   cnt_q, cnt_next;
    logic [WORD_W-1:0]  partial_q, partial_next, assembled, data_ext, word_next;
    logic               valid_next, busy_next;

`ifdef QSPI_RX_LAT_WR_EN
    logic wr_accept;
    logic err_next;

    assign wr_accept = lat_wr_en && !busy;
    assign err_next  = lat_wr_en && busy;
    // A same-cycle request must already see the newly written latency.
    assign lat_eff   = wr_accept ? clamp_lat(lat_wr_data) : lat_q;
`else
    assign lat_eff   = lat_q;
`endif

    assign latency = lat_q;

    // Strap pins turn into data pins at reset release, so this flop only samples while rst_n is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat_q <= clamp_lat(strap_lat);
`ifdef QSPI_RX_LAT_WR_EN
        end else if (wr_accept) begin
            lat_q <= clamp_lat(lat_wr_data);
`endif
        end
    end

    always_comb begin
        lat_mask   = '0;
        capture_dl = 1'b0;
        for (int i = 0; i < MAX_LAT; i++) begin
            lat_mask[i] = (LAT_W'(i) < lat_eff);
            if (lat_eff == LAT_W'(i + 1)) begin
                capture_dl = dl_q[i];
            end
        end
    end

    // Bits shifted past the tap are already consumed; masking keeps busy honest.
    assign capture = (lat_eff == '0) ? sample_req : capture_dl;
    assign dl_next = abort ? '0 : (((dl_q << 1) | MAX_LAT'(sample_req)) & lat_mask);

    assign data_ext  = WORD_W'(qspi_data_in);
    assign assembled = MSB_FIRST ? ((partial_q << DATA_W) | data_ext)
                                 : ((partial_q >> DATA_W) | (data_ext << (WORD_W - DATA_W)));

    always_comb begin
        cnt_next     = cnt_q;
        partial_next = partial_q;
        word_next    = word_out;
        valid_next   = 1'b0;
        if (abort) begin
            cnt_next     = '0;
            partial_next = '0;
        end else if (capture) begin
            if (cnt_q == CNT_W'(BEATS - 1)) begin
                cnt_next     = '0;
                partial_next = '0;
                word_next    = assembled;
                valid_next   = 1'b1;
            end else begin
                cnt_next     = cnt_q + 1'b1;
                partial_next = assembled;
            end
        end
        busy_next = (|dl_next) || (cnt_next != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_q       <= '0;
            cnt_q      <= '0;
            partial_q  <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            dl_q       <= dl_next;
            cnt_q      <= cnt_next;
            partial_q  <= partial_next;
            word_out   <= word_next;
            word_valid <= valid_next;
            busy       <= busy_next;
        end
    end

`ifdef QSPI_RX_LAT_WR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_wr_err <= 1'b0;
        end else begin
            lat_wr_err <= err_next;
        end
    end
`endif

endmodule

// File: tb/tb_qspi_rx_latency_align.sv
// Randomized and directed bench for qspi_rx_latency_align against a queue-based timing model.
module tb_qspi_rx_latency_align;

    localparam int DATA_W  = 4;
    localparam int WORD_W  = 8;
    localparam int MAX_LAT = 7;
    localparam int LAT_W   = 4;
    localparam int BEATS   = WORD_W / DATA_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [LAT_W-1:0]  strap_lat = '0;
    logic              sample_req = 1'b0;
    logic              abort = 1'b0;
    logic [DATA_W-1:0] qspi_data_in = '0;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              busy;
    logic [LAT_W-1:0]  latency;
    logic              lat_wr_en = 1'b0;
    logic [LAT_W-1:0]  lat_wr_data = '0;
`ifdef QSPI_RX_LAT_WR_EN
    logic              lat_wr_err;
`endif

    qspi_rx_latency_align #(
        .DATA_W(DATA_W), .WORD_W(WORD_W), .MAX_LAT(MAX_LAT), .LAT_W(LAT_W), .MSB_FIRST(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .strap_lat(strap_lat), .sample_req(sample_req), .abort(abort),
        .qspi_data_in(qspi_data_in), .word_out(word_out), .word_valid(word_valid), .busy(busy),
        .latency(latency)
`ifdef QSPI_RX_LAT_WR_EN
        , .lat_wr_en(lat_wr_en), .lat_wr_data(lat_wr_data), .lat_wr_err(lat_wr_err)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: each request becomes a due edge number; captured beats queue up until a word is full.
    int cyc;
    int due_q[$];
    int beat_q[$];
    int m_lat;
    int m_word;
    bit m_wv;
    bit m_busy;
    bit m_err;

    function automatic int clampi(input int v);
        return (v > MAX_LAT) ? MAX_LAT : v;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit req, input bit ab, input int data);
        int d;
        sample_req   = req;
        abort        = ab;
        qspi_data_in = DATA_W'(data);
        d            = data & ((1 << DATA_W) - 1);
        @(posedge clk);
        m_err = 1'b0;
        if (lat_wr_en) begin
            if (m_busy) m_err = 1'b1;
            else        m_lat = clampi(int'(lat_wr_data));
        end
        m_wv = 1'b0;
        if (ab) begin
            due_q.delete();
            beat_q.delete();
        end else begin
            if (req) due_q.push_back(cyc + m_lat);
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                void'(due_q.pop_front());
                beat_q.push_back(d);
                if (beat_q.size() == BEATS) begin
                    m_word = 0;
                    foreach (beat_q[i]) m_word = (m_word << DATA_W) | beat_q[i];
                    m_wv = 1'b1;
                    beat_q.delete();
                end
            end
        end
        m_busy = (due_q.size() > 0) || (beat_q.size() > 0);
        cyc++;
        #1;
        check("word_out", int'(word_out), m_word);
        check("word_valid", int'(word_valid), int'(m_wv));
        check("busy", int'(busy), int'(m_busy));
        check("latency", int'(latency), m_lat);
`ifdef QSPI_RX_LAT_WR_EN
        check("lat_wr_err", int'(lat_wr_err), int'(m_err));
`endif
    endtask

    task automatic do_reset(input int s);
        rst_n      = 1'b0;
        strap_lat  = LAT_W'(s);
        sample_req = 1'b0;
        abort      = 1'b0;
        lat_wr_en  = 1'b0;
        #1;
        check("rst_word_out", int'(word_out), 0);
        check("rst_word_valid", int'(word_valid), 0);
        check("rst_busy", int'(busy), 0);
`ifdef QSPI_RX_LAT_WR_EN
        check("rst_lat_wr_err", int'(lat_wr_err), 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_latency", int'(latency), clampi(s));
        rst_n     = 1'b1;
        strap_lat = LAT_W'($urandom);
        due_q.delete();
        beat_q.delete();
        m_lat  = clampi(s);
        m_word = 0;
        m_wv   = 1'b0;
        m_busy = 1'b0;
        m_err  = 1'b0;
        cyc    = 0;
    endtask

    initial begin
        // Strap 3: beats A then 5 form 0xA5.
        do_reset(3);
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 4'hA);
        check("a5_no_early_valid", int'(word_valid), 0);
        step(0, 0, 4'h5);
        check("a5_word", int'(word_out), 8'hA5);
        check("a5_valid", int'(word_valid), 1);
        step(0, 0, 0);
        check("a5_valid_drop", int'(word_valid), 0);
        check("a5_idle", int'(busy), 0);

        // Back-to-back words at latency 0 and 7.
        for (int li = 0; li < 2; li++) begin
            int lat;
            lat = (li == 0) ? 0 : 7;
            do_reset(lat);
            for (int i = 0; i <= lat + 7; i++) begin
                step(i < 8, 0, (i >= lat) ? (i - lat + 1) : 0);
                if (i >= lat && ((i - lat) % 2) == 1) begin
                    check("b2b_word", int'(word_out), ((i - lat) << 4) | (i - lat + 1));
                    check("b2b_valid", int'(word_valid), 1);
                end
            end
        end

        // Strap above MAX_LAT clamps; pin activity after release leaves latency alone.
        do_reset(9);
        for (int i = 0; i < 3; i++) begin
            strap_lat = LAT_W'($urandom);
            step(0, 0, 0);
        end
        check("clamp_hold", int'(latency), 7);

        // Abort together with a request after one captured beat.
        do_reset(2);
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 9);
        step(0, 0, 4'hC);
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 6);
        step(1, 1, 0);
        check("abort_word_kept", int'(word_out), 8'h9C);
        check("abort_no_valid", int'(word_valid), 0);
        check("abort_busy", int'(busy), 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 4'hD);
        step(0, 0, 2);
        check("abort_clean_word", int'(word_out), 8'hD2);

        // Mid-word async reset after a completed word.
        do_reset(1);
        step(1, 0, 0);
        step(1, 0, 3);
        step(1, 0, 4);
        step(0, 0, 5);
        check("mid_pre_word", int'(word_out), 8'h34);
        do_reset(1);
        step(0, 0, 0);
        check("mid_latency", int'(latency), 1);

`ifdef QSPI_RX_LAT_WR_EN
        do_reset(0);
        lat_wr_en   = 1'b1;
        lat_wr_data = 4'd5;
        step(0, 0, 0);
        lat_wr_en   = 1'b0;
        check("wr_idle_lat", int'(latency), 5);
        step(1, 0, 0);
        lat_wr_en   = 1'b1;
        lat_wr_data = 4'd2;
        step(0, 0, 0);
        lat_wr_en   = 1'b0;
        check("wr_busy_err", int'(lat_wr_err), 1);
        check("wr_busy_lat", int'(latency), 5);
        repeat (8) step(0, 0, 0);
`endif

        // Randomized traffic with occasional aborts.
        for (int r = 0; r < 6; r++) begin
            do_reset($urandom_range(0, 15));
            for (int i = 0; i < 200; i++) begin
`ifdef QSPI_RX_LAT_WR_EN
                lat_wr_en   = ($urandom % 30) == 0;
                lat_wr_data = LAT_W'($urandom);
`endif
                step(($urandom % 3) != 0, ($urandom % 30) == 0, int'($urandom));
            end
            lat_wr_en = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
